// File: rtl/io_port_bank_pkg.sv
// Shared constants for the I/O port bank: default bus addresses and status word layout.
// Imported by the RTL and by the benches so address maps stay in one place.
package io_port_bank_pkg;

  localparam int DEF_IN_BASE   = 'h41;
  localparam int DEF_OUT_BASE  = 'h40;
  localparam int DEF_STRM_ADDR = 'h7E;
  localparam int DEF_STAT_ADDR = 'h7F;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;

endpackage

// File: rtl/io_stream_fifo.sv
// Synchronous stream FIFO with valid/ready head; pushes while full are dropped
// regardless of a same-cycle pop, and the head data reads 0 whenever it is empty.
module io_stream_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  input  logic              ready,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign head_valid = !empty;
  assign head_data  = empty ? '0 : mem_reg[rd_ptr_reg];

  // Full/empty decisions use the count from before this edge.
  assign push_ok = push && !full;
  assign pop_ok  = ready && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: synchronised inputs with change flags, latched outputs,
// a buffered output stream and a level interrupt for input change or stream overflow.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int N_IN       = 2,
  parameter int N_OUT      = 2,
  parameter int IN_BASE    = DEF_IN_BASE,
  parameter int OUT_BASE   = DEF_OUT_BASE,
  parameter int STRM_ADDR  = DEF_STRM_ADDR,
  parameter int STAT_ADDR  = DEF_STAT_ADDR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic                    bus_we,
  input  logic [DATA_W-1:0]       bus_wdata,
  input  logic                    bus_re,
  output logic [DATA_W-1:0]       bus_rdata,
  input  logic [N_IN*DATA_W-1:0]  io_in,
  output logic [N_OUT*DATA_W-1:0] io_out,
  input  logic [N_IN-1:0]         irq_mask,
  output logic [DATA_W-1:0]       strm_data,
  output logic                    strm_valid,
  input  logic                    strm_ready,
  output logic                    irq
);

  logic [N_IN*DATA_W-1:0] in_sync;
  logic [N_IN-1:0]        changed;
  logic                   stat_rd;
  logic                   push_req;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   overflow_reg;
  logic                   irq_reg;
  logic [DATA_W-1:0]      rdata_reg;
  logic [DATA_W-1:0]      rd_mux;
  logic [DATA_W-1:0]      status;

  assign stat_rd  = bus_re && (bus_addr == ADDR_W'(STAT_ADDR));
  assign push_req = bus_we && (bus_addr == ADDR_W'(STRM_ADDR));

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    logic [DATA_W-1:0] sync1_reg;
    logic [DATA_W-1:0] sync2_reg;
    logic [DATA_W-1:0] shadow_reg;
    logic              changed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_reg   <= '0;
        sync2_reg   <= '0;
        shadow_reg  <= '0;
        changed_reg <= 1'b0;
      end else begin
        sync1_reg  <= io_in[gi*DATA_W +: DATA_W];
        sync2_reg  <= sync1_reg;
        shadow_reg <= sync2_reg;
        // A new change wins over a clearing status read in the same cycle.
        if (sync2_reg != shadow_reg) changed_reg <= 1'b1;
        else if (stat_rd)            changed_reg <= 1'b0;
      end
    end

    assign in_sync[gi*DATA_W +: DATA_W] = sync2_reg;
    assign changed[gi]                  = changed_reg;
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    logic [DATA_W-1:0] out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        out_reg <= '0;
      else if (bus_we && (bus_addr == ADDR_W'(OUT_BASE + 2*gi)))
        out_reg <= bus_wdata;
    end

    assign io_out[gi*DATA_W +: DATA_W] = out_reg;
  end

  io_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_req),
    .push_data  (bus_wdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .ready      (strm_ready),
    .head_data  (strm_data),
    .head_valid (strm_valid)
  );

  always_comb begin
    status                = '0;
    status[N_IN-1:0]      = changed;
    status[ST_EMPTY]      = fifo_empty;
    status[ST_FULL]       = fifo_full;
    status[ST_OVF]        = overflow_reg;
  end

  // Reads sample the pre-edge state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_IN; k++)
      if (bus_addr == ADDR_W'(IN_BASE + 2*k)) rd_mux = in_sync[k*DATA_W +: DATA_W];
    for (int k = 0; k < N_OUT; k++)
      if (bus_addr == ADDR_W'(OUT_BASE + 2*k)) rd_mux = io_out[k*DATA_W +: DATA_W];
    if (bus_addr == ADDR_W'(STAT_ADDR)) rd_mux = status;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg    <= '0;
      overflow_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      if (bus_re) rdata_reg <= rd_mux;
      if (push_req && fifo_full) overflow_reg <= 1'b1;
      else if (stat_rd)          overflow_reg <= 1'b0;
      irq_reg <= (|(changed & irq_mask)) | overflow_reg;
    end
  end

  assign bus_rdata = rdata_reg;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: expected read data and stream words are queued
// at issue time and compared by a monitor when the DUT presents them.
module tb_io_port_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bus_addr = '0;
  logic        bus_we = 1'b0;
  logic [15:0] bus_wdata = '0;
  logic        bus_re = 1'b0;
  logic [15:0] bus_rdata;
  logic [31:0] io_in = '0;
  logic [31:0] io_out;
  logic [1:0]  irq_mask = '0;
  logic [15:0] strm_data;
  logic        strm_valid;
  logic        strm_ready = 1'b0;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } rd_exp_t;

  rd_exp_t     rq[$];
  logic [15:0] sq[$];
  logic        re_d;

  io_port_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .io_in      (io_in),
    .io_out     (io_out),
    .irq_mask   (irq_mask),
    .strm_data  (strm_data),
    .strm_valid (strm_valid),
    .strm_ready (strm_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) re_d <= 1'b0;
    else        re_d <= bus_re;
  end

  // Monitor: one pop per presented read result / stream transfer.
  always @(negedge clk) begin
    if (rst_n && re_d) begin
      if (rq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_read: got %h expected nothing", bus_rdata);
      end else begin
        rd_exp_t e;
        e = rq.pop_front();
        check(e.name, {16'h0, bus_rdata}, {16'h0, e.exp});
      end
    end
    if (rst_n && strm_valid && strm_ready) begin
      if (sq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_stream: got %h expected nothing", strm_data);
      end else begin
        logic [15:0] w;
        w = sq.pop_front();
        check("stream_word", {16'h0, strm_data}, {16'h0, w});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    tick(1);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [15:0] exp, input string name);
    rd_exp_t e;
    e.exp = exp; e.name = name;
    rq.push_back(e);
    bus_addr = a; bus_re = 1'b1;
    tick(1);
    bus_re = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] d, input bit accepted);
    if (accepted) sq.push_back(d);
    bus_write(8'h7E, d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    #50;
    check("rst_io_out", io_out, 32'h0);
    check("rst_valid", {31'h0, strm_valid}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", {16'h0, bus_rdata}, 32'h0);
    check("rst_strm_data", {16'h0, strm_data}, 32'h0);
    #50;
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    bus_read(8'h7F, 16'h0100, "rst_status");

    // 2: output ports
    bus_write(8'h40, 16'h1234);
    bus_write(8'h42, 16'hBEEF);
    check("io_out_pair", io_out, 32'hBEEF_1234);
    bus_read(8'h40, 16'h1234, "rd_out0");
    bus_read(8'h42, 16'hBEEF, "rd_out1");
    bus_write(8'h41, 16'hFFFF);
    bus_read(8'h41, 16'h0000, "in0_write_ignored");
    bus_read(8'h50, 16'h0000, "rd_unmapped");

    // 3: input change and interrupt
    irq_mask = 2'b10;
    io_in[31:16] = 16'h00A5;
    tick(4);
    check("irq_on_change", {31'h0, irq}, 32'h1);
    bus_read(8'h43, 16'h00A5, "rd_in1");
    bus_read(8'h7F, 16'h0102, "status_changed1");
    check("irq_held_at_clear", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    bus_read(8'h7F, 16'h0100, "status_after_clear");
    io_in[15:0] = 16'h0003;
    tick(4);
    check("irq_masked", {31'h0, irq}, 32'h0);
    bus_read(8'h7F, 16'h0101, "status_changed0");
    bus_read(8'h41, 16'h0003, "rd_in0");

    // 4: fill, overflow, drain
    for (int i = 1; i <= 5; i++) push_word(16'(i), i <= 4);
    check("head_valid", {31'h0, strm_valid}, 32'h1);
    check("head_stable", {16'h0, strm_data}, 32'h1);
    bus_read(8'h7F, 16'h0600, "status_full_ovf");
    check("irq_overflow", {31'h0, irq}, 32'h1);
    strm_ready = 1'b1;
    tick(4);
    strm_ready = 1'b0;
    check("drained_valid", {31'h0, strm_valid}, 32'h0);
    check("irq_after_ovf_clear", {31'h0, irq}, 32'h0);

    // 5: push while full with a same-cycle pop
    for (int i = 0; i < 4; i++) push_word(16'hA0 + 16'(i), 1'b1);
    strm_ready = 1'b1;
    push_word(16'h00A4, 1'b0);
    strm_ready = 1'b0;
    bus_read(8'h7F, 16'h0400, "status_ovf_count3");
    strm_ready = 1'b1;
    tick(3);
    strm_ready = 1'b0;
    check("drained_valid2", {31'h0, strm_valid}, 32'h0);
    bus_read(8'h7F, 16'h0100, "status_empty");

    // 6: reset during drain
    for (int i = 0; i < 3; i++) push_word(16'hB0 + 16'(i), 1'b1);
    strm_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    strm_ready = 1'b0;
    io_in = '0;
    #1;
    check("midrst_valid", {31'h0, strm_valid}, 32'h0);
    check("midrst_io_out", io_out, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    sq.delete();
    tick(3);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    check("post_rst_valid", {31'h0, strm_valid}, 32'h0);
    bus_read(8'h7F, 16'h0100, "post_rst_status");
    tick(2);

    check("read_queue_empty", rq.size(), 32'h0);
    check("stream_queue_empty", sq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
